// File: rtl/keypad_scan_debounce_pkg.sv
// Shared constants, column encodings and the key-position map for the keypad scanner.
package keypad_scan_debounce_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Column states double as the one-hot strobe pattern driven onto key_col.
  typedef enum logic [2:0] {
    COL_IDLE = 3'b000,
    COL1     = 3'b001,
    COL2     = 3'b010,
    COL3     = 3'b100
  } col_t;

  function automatic logic [3:0] keymap(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer (slave).
interface keypad_scan_debounce_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scan_debounce_debouncer.sv
// Frame-level debouncer: promotes a frame code to the stable code after DEBOUNCE_CNT identical frames.
module keypad_debouncer
  import keypad_scan_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  logic [3:0] frame_code,
  output logic [3:0] stable,
  output logic       press,
  output logic       key_held
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic       accept;

  always_comb begin
    cand_n = cand;
    cnt_n  = cnt;
    if (frame_done) begin
      if (frame_code == cand) begin
        cnt_n = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 4'd1;
      end else begin
        cand_n = frame_code;
        cnt_n  = 4'd1;
      end
    end
    accept = frame_done && (cnt_n == CNT_MAX) && (cand_n != stable);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand     <= KEY_NONE;
      cnt      <= '0;
      stable   <= KEY_NONE;
      press    <= 1'b0;
      key_held <= 1'b0;
    end else begin
      cand     <= cand_n;
      cnt      <= cnt_n;
      press    <= accept && (cand_n != KEY_NONE);
      if (accept) begin
        stable   <= cand_n;
        key_held <= (cand_n != KEY_NONE);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 3x4 keypad scanner: column strobing, frame accumulation with ghost rejection,
// debouncing and a buffered valid/ack key-press event.
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12500,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key_row,
  output logic [2:0]                    key_col,
  keypad_scan_debounce_if.master        key_if
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  col_t             col_q, col_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= key_row;
      row_s2 <= row_s1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) col_q <= COL_IDLE;
    else     col_q <= col_d;
  end

  always_comb begin
    col_d = col_q;
    if (tick) begin
      case (col_q)
        COL1:    col_d = COL2;
        COL2:    col_d = COL3;
        default: col_d = COL1;
      endcase
    end
  end

  assign key_col = col_q;

  logic [1:0] col_idx, row_idx;
  logic       hit_any, hit_one;
  logic [3:0] samp_code;
  logic       acc_hit, acc_multi;
  logic [3:0] acc_code;
  logic       new_hit, new_multi;
  logic [3:0] new_code;
  logic       col_active, frame_done;
  logic [3:0] frame_code;

  always_comb begin
    case (col_q)
      COL2:    col_idx = 2'd1;
      COL3:    col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
    if      (row_s2[3]) row_idx = 2'd3;
    else if (row_s2[2]) row_idx = 2'd2;
    else if (row_s2[1]) row_idx = 2'd1;
    else                row_idx = 2'd0;
  end

  assign hit_any   = |row_s2;
  assign hit_one   = $onehot(row_s2);
  assign samp_code = keymap(col_idx, row_idx);

  // The COL3 sample is folded in combinationally so the frame result is ready on its own tick.
  always_comb begin
    col_active = tick && (col_q != COL_IDLE);
    frame_done = tick && (col_q == COL3);
    new_hit    = acc_hit | hit_any;
    new_multi  = acc_multi | (hit_any & (~hit_one | acc_hit));
    new_code   = (hit_one && !acc_hit) ? samp_code : acc_code;
    frame_code = (!new_hit || new_multi) ? KEY_NONE : new_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= KEY_NONE;
    end else if (col_active) begin
      if (frame_done) begin
        acc_hit   <= 1'b0;
        acc_multi <= 1'b0;
        acc_code  <= KEY_NONE;
      end else begin
        acc_hit   <= new_hit;
        acc_multi <= new_multi;
        acc_code  <= new_code;
      end
    end
  end

  logic [3:0] stable;
  logic       press;

  keypad_debouncer #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .frame_code (frame_code),
    .stable     (stable),
    .press      (press),
    .key_held   (key_if.key_held)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_if.key_valid <= 1'b0;
      key_if.key_code  <= KEY_NONE;
      key_if.overrun   <= 1'b0;
    end else if (press) begin
      if (!key_if.key_valid) begin
        key_if.key_valid <= 1'b1;
        key_if.key_code  <= stable;
      end else if (key_if.key_ack) begin
        key_if.key_code  <= stable;
      end else begin
        key_if.overrun   <= 1'b1;
      end
    end else if (key_if.key_valid && key_if.key_ack) begin
      key_if.key_valid <= 1'b0;
      key_if.overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce: frame-level behavioural model plus directed scenarios.
module tb_keypad_scan_debounce;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam logic [3:0] NONE = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [11:0] keys;

  keypad_scan_debounce_if kif ();

  keypad_scan_debounce #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_row (key_row),
    .key_col (key_col),
    .key_if  (kif)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key connects its column strobe to its row line.
  function automatic logic [3:0] rows_for(input logic [2:0] col, input logic [11:0] k);
    logic [3:0] r;
    int c, rw;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      if (k[i]) begin
        if (i >= 1 && i <= 9) begin
          c  = (i - 1) % 3;
          rw = (i - 1) / 3;
        end else begin
          rw = 3;
          c  = (i == 10) ? 0 : (i == 0) ? 1 : 2;
        end
        if (col[c]) r[rw] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb key_row = rows_for(key_col, keys);

  int nvec = 0;
  int nmis = 0;
  int n_rise = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         mk;
  logic [3:0] m_code, m_stable, ev_code;
  bit         m_valid, m_ovr, m_held, ev_pend;
  logic [3:0] hist[$];

  function automatic bit is_frame_end(input int k);
    return (k >= 4 * SD) && ((k - SD) % (3 * SD) == 0);
  endfunction

  function automatic logic [2:0] exp_col(input int k);
    if (k < SD) return 3'b000;
    case (((k / SD) - 1) % 3)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [3:0] frame_result(input logic [11:0] k);
    if ($countones(k) != 1) return NONE;
    for (int i = 0; i < 12; i++) if (k[i]) return 4'(i);
    return NONE;
  endfunction

  initial forever begin
    logic [3:0] res;
    bit same;
    @(posedge clk or posedge rst);
    if (rst) begin
      mk = 0; m_code = NONE; m_stable = NONE; ev_code = NONE;
      m_valid = 0; m_ovr = 0; m_held = 0; ev_pend = 0;
      hist.delete();
    end else begin
      mk++;
      if (ev_pend) begin
        if (!m_valid) begin m_valid = 1; m_code = ev_code; end
        else if (kif.key_ack) m_code = ev_code;
        else m_ovr = 1;
        ev_pend = 0;
      end else if (m_valid && kif.key_ack) begin
        m_valid = 0; m_ovr = 0;
      end
      if (is_frame_end(mk)) begin
        res = frame_result(keys);
        hist.push_back(res);
        if (hist.size() > DB) void'(hist.pop_front());
        same = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != res) same = 0;
        if (same && res != m_stable) begin
          m_stable = res;
          if (res != NONE) begin ev_pend = 1; ev_code = res; end
        end
        m_held = (m_stable != NONE);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit prev_valid;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      chk("key_col",   int'(key_col),       int'(exp_col(mk)));
      chk("key_code",  int'(kif.key_code),  int'(m_code));
      chk("key_valid", int'(kif.key_valid), int'(m_valid));
      chk("key_held",  int'(kif.key_held),  int'(m_held));
      chk("overrun",   int'(kif.overrun),   int'(m_ovr));
      if (kif.key_valid && !prev_valid) n_rise++;
      prev_valid = kif.key_valid;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic to_frame_end();
    int guard;
    guard = 0;
    do begin
      step(1);
      guard++;
    end while (!is_frame_end(mk) && guard < 20);
    if (!is_frame_end(mk)) chk("frame_timeout", guard, 0);
  endtask

  task automatic frames(input int n);
    repeat (n) to_frame_end();
  endtask

  task automatic ack_pulse();
    kif.key_ack = 1'b1;
    step(1);
    kif.key_ack = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int valid, input int code,
                         input int held, input int ovr);
    chk({tag, "_valid"}, int'(kif.key_valid), valid);
    chk({tag, "_code"},  int'(kif.key_code),  code);
    chk({tag, "_held"},  int'(kif.key_held),  held);
    chk({tag, "_ovr"},   int'(kif.overrun),   ovr);
  endtask

  initial begin
    rst = 1'b1;
    keys = '0;
    kif.key_ack = 1'b0;
    step(3);
    chk("rst_col", int'(key_col), 0);
    chk_out("rst", 0, 'hF, 0, 0);
    rst = 1'b0;

    // Column strobe sequence, each strobe SD clocks long.
    step(2);  chk("col_idle", int'(key_col), 3'b000);
    step(3);  chk("col_1",    int'(key_col), 3'b001);
    step(4);  chk("col_2",    int'(key_col), 3'b010);
    step(4);  chk("col_3",    int'(key_col), 3'b100);
    step(4);  chk("col_1b",   int'(key_col), 3'b001);

    // Key 5 held for 5 frames: single event, no repeat after ack.
    to_frame_end();
    keys = 12'(1 << 5);
    frames(5);
    chk_out("k5", 1, 5, 1, 0);
    chk("k5_rises", n_rise, 1);
    ack_pulse();
    chk("k5_ack_valid", int'(kif.key_valid), 0);
    frames(2);
    chk("k5_norepeat", n_rise, 1);
    keys = '0;
    frames(4);
    chk("k5_release_held", int'(kif.key_held), 0);

    // Key 7 on alternate frames never settles.
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 12'(1 << 7) : 12'd0;
      to_frame_end();
    end
    chk_out("bounce", 0, 5, 0, 0);
    keys = '0;
    frames(3);

    // Keys 1 and 3 together are rejected; releasing 3 yields key 1.
    keys = 12'((1 << 1) | (1 << 3));
    frames(6);
    chk("ghost_held",  int'(kif.key_held),  0);
    chk("ghost_valid", int'(kif.key_valid), 0);
    keys = 12'(1 << 1);
    frames(4);
    chk_out("k1", 1, 1, 1, 0);
    ack_pulse();
    chk("k1_ack_valid", int'(kif.key_valid), 0);
    keys = '0;
    frames(4);

    // Press 2 unacknowledged, then 9: 9 is dropped and flagged.
    keys = 12'(1 << 2);
    frames(4);
    chk_out("k2", 1, 2, 1, 0);
    keys = '0;
    frames(4);
    chk_out("k2_rel", 1, 2, 0, 0);
    keys = 12'(1 << 9);
    frames(4);
    chk_out("k9_drop", 1, 2, 1, 1);
    ack_pulse();
    chk("ovr_ack_valid", int'(kif.key_valid), 0);
    chk("ovr_ack_ovr",   int'(kif.overrun),   0);
    keys = '0;
    frames(4);

    // '#' held through a mid-frame reset produces a fresh event.
    keys = 12'(1 << 11);
    frames(4);
    chk_out("hash", 1, 11, 1, 0);
    step(5);
    rst = 1'b1;
    #1;
    chk("mid_rst_col", int'(key_col), 0);
    chk_out("mid_rst", 0, 'hF, 0, 0);
    step(2);
    rst = 1'b0;
    frames(3);
    chk("hash_pre_valid", int'(kif.key_valid), 0);
    chk("hash_pre_held",  int'(kif.key_held),  1);
    step(1);
    chk_out("hash_post", 1, 11, 1, 0);
    keys = '0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
